dmem_byte_sequencer: RTL and testbench

//  MEM-stage controller that turns one 32-bit load/store into four sequenced byte accesses.
//  It targets the byte-wide data memory (memory[i] is 8 bits, little-endian: word = {m[a+3],m[a+2],m[a+1],m[a]}).
//  It freezes the CPU pipeline through stall_o until the word transfer completes.
//  It sits between the MEM stage (MemRead/MemWrite, ALU address, rs2 data) and Data_Memory.

---
 rtl/dmem_seq_pkg.sv | 37 +++
 rtl/dmem_read_assembler.sv | 71 +++++++
 rtl/dmem_byte_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_byte_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_seq_pkg.sv
// ---------------------------------------------------------------------------
// dmem_seq_pkg
// Shared definitions for the data-memory byte sequencer:
//   - state_e        : sequencer FSM encoding (IDLE=0, XFER=1, DRAIN=2, DONE=3)
//   - BYTES_PER_WORD : bytes moved per 32-bit word transfer
//   - LANE_W         : width of a byte-lane index within a word
//   - word_byte()    : little-endian lane extraction (lane 0 = bits [7:0])
// ---------------------------------------------------------------------------
package dmem_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  // Little-endian lane select: lane n of the word is bits [8n+7:8n].
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] word,
                                           input logic [LANE_W-1:0] lane);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane == LANE_W'(i)) begin
        b = word[i*8 +: 8];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/dmem_read_assembler.sv
// ---------------------------------------------------------------------------
// dmem_read_assembler
// Collects the bytes of a load into a staging word, one lane at a time, and
// publishes the finished word on commit. The published word only changes on
// commit, so the last loaded value stays visible while a new load is in
// progress.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-low reset
//   clear_i       zero the staging word (start of a new request)
//   cap_en_i      write cap_byte_i into lane cap_lane_i this cycle
//   cap_lane_i    little-endian byte lane to write
//   cap_byte_i    byte to capture
//   commit_i      publish staging word (including this cycle's capture)
//   rdata_o       last published word
// ---------------------------------------------------------------------------
module dmem_read_assembler
  import dmem_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              cap_en_i,
  input  logic [LANE_W-1:0] cap_lane_i,
  input  logic [7:0]        cap_byte_i,
  input  logic              commit_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] stage_q, stage_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] cap_word_s;

  // Merge this cycle's byte into the staging word and decide what to publish.
  always_comb begin
    cap_word_s = stage_q;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (cap_en_i && (cap_lane_i == LANE_W'(i))) begin
        cap_word_s[i*8 +: 8] = cap_byte_i;
      end else begin
        cap_word_s[i*8 +: 8] = stage_q[i*8 +: 8];
      end
    end

    if (clear_i) begin
      stage_d = '0;
    end else begin
      stage_d = cap_word_s;
    end

    // The final lane arrives in the commit cycle, so publish the merged word.
    if (commit_i) begin
      word_d = cap_word_s;
    end else begin
      word_d = word_q;
    end
  end

  // Staging and published word registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stage_q <= '0;
      word_q  <= '0;
    end else begin
      stage_q <= stage_d;
      word_q  <= word_d;
    end
  end

  assign rdata_o = word_q;

endmodule

// File: rtl/dmem_byte_sequencer.sv
// ---------------------------------------------------------------------------
// dmem_byte_sequencer
// MEM-stage controller that splits one 32-bit load/store into four byte
// accesses to a byte-wide, synchronous-read data memory, stalling the
// pipeline until the word transfer completes.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   start_i             CPU run enable; requests accepted only while high
//   req_valid_i         MEM stage has a load or store
//   req_we_i            1 = store, 0 = load
//   req_addr_i          byte address (low ADDR_W bits used)
//   req_wdata_i         store data
//   stall_o             freeze upstream pipeline registers
//   rdata_o             assembled load word (holds until next load completes)
//   rdata_valid_o       one-cycle pulse when a load completes
//   mem_addr_o          byte address to data memory
//   mem_we_o            byte write strobe
//   mem_wdata_o         byte write data
//   mem_rdata_i         byte read data, one cycle after mem_addr_o
//   misalign_o          sticky flag: an accepted address was not word aligned
//   stall_cnt_o         saturating count of stalled cycles
// ---------------------------------------------------------------------------
module dmem_byte_sequencer
  import dmem_seq_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int BYTES  = BYTES_PER_WORD,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rdata_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [LANE_W-1:0]   cnt_q, cnt_d;
  logic                misalign_q, misalign_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic                stall_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic                mem_we_s;
  logic [7:0]          mem_wdata_s;
  logic                rdata_valid_s;
  logic                asm_clear_s;
  logic                asm_cap_en_s;
  logic [LANE_W-1:0]   asm_cap_lane_s;
  logic                asm_commit_s;

  // Only the low ADDR_W address bits reach the memory.
  logic                unused_addr_s;
  assign unused_addr_s = ^req_addr_i[31:ADDR_W];

  // Next-state, datapath latching and memory-port decode.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    misalign_d     = misalign_q;
    stall_s        = 1'b0;
    mem_addr_s     = '0;
    mem_we_s       = 1'b0;
    mem_wdata_s    = 8'h00;
    rdata_valid_s  = 1'b0;
    asm_clear_s    = 1'b0;
    asm_cap_en_s   = 1'b0;
    asm_cap_lane_s = '0;
    asm_commit_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && req_valid_i) begin
          // Stall in the accept cycle itself so the request is held stable.
          stall_s     = 1'b1;
          base_d      = req_addr_i[ADDR_W-1:0];
          we_d        = req_we_i;
          wdata_d     = req_wdata_i;
          cnt_d       = '0;
          asm_clear_s = 1'b1;
          if (req_addr_i[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end else begin
            misalign_d = misalign_q;
          end
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_XFER: begin
        stall_s     = 1'b1;
        // Address arithmetic wraps at the top of the memory.
        mem_addr_s  = base_q + ADDR_W'(cnt_q);
        mem_we_s    = we_q;
        mem_wdata_s = word_byte(wdata_q, cnt_q);
        // Sync read: data on mem_rdata_i belongs to the previous lane.
        if (!we_q && (cnt_q != '0)) begin
          asm_cap_en_s   = 1'b1;
          asm_cap_lane_s = cnt_q - LANE_W'(1);
        end else begin
          asm_cap_en_s   = 1'b0;
        end
        if (cnt_q == LAST_LANE) begin
          if (we_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          cnt_d = cnt_q + LANE_W'(1);
        end
      end

      ST_DRAIN: begin
        // Collect the byte read in the last XFER cycle and publish the word.
        stall_s        = 1'b1;
        asm_cap_en_s   = 1'b1;
        asm_cap_lane_s = LAST_LANE;
        asm_commit_s   = 1'b1;
        state_d        = ST_DONE;
      end

      ST_DONE: begin
        // req_valid_i still reflects the finished request; do not re-accept.
        rdata_valid_s = !we_q;
        state_d       = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (stall_s && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // FSM, latched request and counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0000_0000;
      cnt_q       <= '0;
      misalign_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      misalign_q  <= misalign_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  dmem_read_assembler u_read_assembler (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (asm_clear_s),
    .cap_en_i   (asm_cap_en_s),
    .cap_lane_i (asm_cap_lane_s),
    .cap_byte_i (mem_rdata_i),
    .commit_i   (asm_commit_s),
    .rdata_o    (rdata_o)
  );

  // The IDLE stall is combinational from the request; mask it while reset is
  // held so a pending request cannot freeze the pipeline during reset.
  assign stall_o       = stall_s & rst_i;
  assign rdata_valid_o = rdata_valid_s;
  assign mem_addr_o    = mem_addr_s;
  assign mem_we_o      = mem_we_s;
  assign mem_wdata_o   = mem_wdata_s;
  assign misalign_o    = misalign_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_dmem_byte_sequencer.sv
module tb_dmem_byte_sequencer;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic        req_valid_i;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic [4:0]  mem_addr_o;
  logic        mem_we_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        misalign_o;
  logic [15:0] stall_cnt_o;

  logic [7:0]  mem [32];
  logic        mem_init;

  int checks = 0;
  int errors = 0;

  dmem_byte_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .req_valid_i   (req_valid_i),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .misalign_o    (misalign_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide data memory with synchronous read; preset to 0x40+i.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(8'h40 + i);
      mem_rdata_i <= 8'h00;
    end else begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      mem_rdata_i <= mem[mem_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count stall cycles from the next negedge until the first unstalled cycle.
  task automatic wait_done(output int stalls, output int pulses,
                           output logic [31:0] got, output logic done);
    stalls = 0; pulses = 0; got = 32'h0; done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (stall_o) begin
        stalls++;
      end else begin
        if (rdata_valid_o) begin
          pulses++;
          got = rdata_o;
        end
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk); #1;
    start_i = 1'b1; req_valid_i = 1'b1;
    req_we_i = we; req_addr_i = addr; req_wdata_i = wd;
  endtask

  int          st, pl, st2;
  logic [31:0] got;
  logic        dn;
  int          bad;

  initial begin
    rst_i = 1'b0; mem_init = 1'b1;
    start_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_stall", {31'h0, stall_o}, 32'h0);
    check("rst_outs", {rdata_o[31:0]}, 32'h0);
    check("rst_misc", {rdata_valid_o, mem_we_o, misalign_o, mem_addr_o, mem_wdata_o, stall_cnt_o}, 32'h0);
    mem_init = 1'b0;
    rst_i = 1'b1;

    // 1: aligned store
    drive_req(1'b1, 32'h04, 32'hDEADBEEF);
    wait_done(st, pl, got, dn);
    req_valid_i = 1'b0;
    check("t1_done", {31'h0, dn}, 32'h1);
    check("t1_stalls", st, 32'd5);
    check("t1_pulse", pl, 32'd0);
    check("t1_mem", {mem[7], mem[6], mem[5], mem[4]}, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_release", {31'h0, stall_o}, 32'h0);

    // 2: load back
    drive_req(1'b0, 32'h04, 32'h0);
    wait_done(st, pl, got, dn);
    req_valid_i = 1'b0;
    check("t2_done", {31'h0, dn}, 32'h1);
    check("t2_stalls", st, 32'd6);
    check("t2_pulse", pl, 32'd1);
    check("t2_rdata", got, 32'hDEADBEEF);
    @(negedge clk);
    check("t2_pulse_width", {31'h0, rdata_valid_o}, 32'h0);
    check("t2_rdata_hold", rdata_o, 32'hDEADBEEF);
    check("t2_stall_cnt", {16'h0, stall_cnt_o}, 32'd11);
    check("t2_aligned", {31'h0, misalign_o}, 32'h0);

    // 3: misaligned store wrapping past the top of memory
    drive_req(1'b1, 32'h1E, 32'h11223344);
    wait_done(st, pl, got, dn);
    req_valid_i = 1'b0;
    check("t3_stalls", st, 32'd5);
    check("t3_mem", {mem[1], mem[0], mem[31], mem[30]}, 32'h11223344);
    check("t3_neighbours", {16'h0, mem[2], mem[29]}, 32'h0000425D);
    check("t3_misalign", {31'h0, misalign_o}, 32'h1);

    // 4: back-to-back load 0x00 then store 0x08, req_valid_i held high
    drive_req(1'b0, 32'h00, 32'h0);
    wait_done(st, pl, got, dn);
    req_we_i = 1'b1; req_addr_i = 32'h08; req_wdata_i = 32'hCAFEF00D;
    check("t4_ld_stalls", st, 32'd6);
    check("t4_ld_rdata", got, 32'h43421122);
    check("t4_ld_pulse", pl, 32'd1);
    wait_done(st2, pl, got, dn);
    req_valid_i = 1'b0;
    check("t4_st_stalls", st2, 32'd5);
    check("t4_st_pulse", pl, 32'd0);
    check("t4_st_mem", {mem[11], mem[10], mem[9], mem[8]}, 32'hCAFEF00D);
    check("t4_ld_untouched", {mem[3], mem[2], mem[1], mem[0]}, 32'h43421122);
    @(negedge clk);
    check("t4_idle", {31'h0, stall_o}, 32'h0);
    check("t4_stall_cnt", {16'h0, stall_cnt_o}, 32'd27);
    check("t4_rdata_hold", rdata_o, 32'h43421122);

    // 5: reset during XFER cnt=2 of a store to 0x10
    drive_req(1'b1, 32'h10, 32'h55667788);
    repeat (4) @(negedge clk);
    check("t5_cnt2_addr", {27'h0, mem_addr_o}, 32'h12);
    rst_i = 1'b0;
    #1;
    check("t5_rst_stall", {31'h0, stall_o}, 32'h0);
    check("t5_rst_outs", {rdata_valid_o, mem_we_o, misalign_o, mem_addr_o, mem_wdata_o, stall_cnt_o}, 32'h0);
    check("t5_rst_rdata", rdata_o, 32'h0);
    @(negedge clk);
    req_valid_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    check("t5_mem", {mem[19], mem[18], mem[17], mem[16]}, 32'h53527788);

    // 6a: start_i low blocks a request
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h14; req_wdata_i = 32'hFFFFFFFF;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (stall_o || mem_we_o) bad++;
    end
    check("t6_blocked", bad, 32'd0);
    check("t6_mem", {mem[23], mem[22], mem[21], mem[20]}, 32'h57565554);

    // 6b: start_i dropped mid-load; the load still completes
    drive_req(1'b0, 32'h04, 32'h0);
    st = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (stall_o) st++;
    end
    start_i = 1'b0;
    wait_done(st2, pl, got, dn);
    check("t6_done", {31'h0, dn}, 32'h1);
    check("t6_stalls", st + st2, 32'd6);
    check("t6_rdata", got, 32'hDEADBEEF);
    check("t6_pulse", pl, 32'd1);
    @(negedge clk);
    check("t6_no_accept", {31'h0, stall_o}, 32'h0);
    check("t6_stall_cnt", {16'h0, stall_cnt_o}, 32'd6);
    req_valid_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
